// File: rtl/riscv_decode_ctrl_if.sv
// Fetch-side and execute-side handshake bundle for the RV32I decode/control unit.
// The decoder uses the slave modport; whoever feeds instructions and consumes fields uses master.
interface riscv_decode_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_OP_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instr;
    logic                out_valid;
    logic                out_ready;
    logic                reg_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                use_imm;
    logic [XLEN-1:0]     imm;
    logic                illegal;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, reg_write, alu_op, rd, rs1, rs2, use_imm, imm, illegal
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, reg_write, alu_op, rd, rs1, rs2, use_imm, imm, illegal
    );
endinterface

// File: rtl/riscv_decode_ctrl.sv
// Registered RV32I ALU-instruction decoder with valid/ready on both sides,
// a multi-cycle MUL stall, synchronous flush and a retired-instruction counter.
module riscv_decode_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALU_OP_W   = 5,
    parameter int unsigned ENABLE_M   = 1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    riscv_decode_ctrl_if.slave    bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam int unsigned MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_CYCLES - 2);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_AND   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR    = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR   = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SLT   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SLTU  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] OP_MUL   = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] OP_PASSB = ALU_OP_W'(11);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        MULWAIT = 2'd2
    } state_t;

    state_t              state;
    logic [MC_W-1:0]     mul_cnt;
    logic                reg_write_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [4:0]          rd_q;
    logic [4:0]          rs1_q;
    logic [4:0]          rs2_q;
    logic                use_imm_q;
    logic [XLEN-1:0]     imm_q;
    logic                illegal_q;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                accept;

    logic                dec_illegal;
    logic                dec_mul;
    logic                dec_use_imm;
    logic [ALU_OP_W-1:0] dec_op;
    logic [XLEN-1:0]     dec_imm;
    logic [4:0]          dec_rs1;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    // Ready is the only combinational output: it must see flush and out_ready in the same cycle.
    assign bus.in_ready = !flush && ((state == EMPTY) || ((state == FULL) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Instruction decode of the word presented on the input side.
    always_comb begin
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_use_imm = 1'b0;
        dec_op      = OP_ADD;
        dec_imm     = '0;
        dec_rs1     = bus.instr[19:15];
        unique case (opcode)
            OPC_R: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000: dec_op = OP_ADD;
                        3'b001: dec_op = OP_SLL;
                        3'b010: dec_op = OP_SLT;
                        3'b011: dec_op = OP_SLTU;
                        3'b100: dec_op = OP_XOR;
                        3'b101: dec_op = OP_SRL;
                        3'b110: dec_op = OP_OR;
                        3'b111: dec_op = OP_AND;
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = OP_SRA;
                end else if (funct7 == F7_MULD && funct3 == 3'b000 && ENABLE_M != 0) begin
                    dec_op  = OP_MUL;
                    dec_mul = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_I: begin
                dec_use_imm = 1'b1;
                dec_imm     = XLEN'($signed(bus.instr[31:20]));
                unique case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_op      = OP_SLL;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec_op = OP_SRL;
                        else if (funct7 == F7_ALT) dec_op = OP_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_op      = OP_PASSB;
                dec_use_imm = 1'b1;
                dec_imm     = XLEN'($signed({bus.instr[31:12], 12'b0}));
                dec_rs1     = 5'd0;
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal words still flow through, but with a neutral, non-writing control set.
        if (dec_illegal) begin
            dec_mul     = 1'b0;
            dec_use_imm = 1'b0;
            dec_op      = OP_ADD;
            dec_imm     = '0;
        end
    end

    // Pipeline state, MUL countdown, decoded-field registers and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            mul_cnt     <= '0;
            reg_write_q <= 1'b0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
            retire_cnt  <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            mul_cnt <= '0;
        end else begin
            if ((state == FULL) && bus.out_ready) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (accept) begin
                reg_write_q <= !dec_illegal;
                alu_op_q    <= dec_op;
                rd_q        <= bus.instr[11:7];
                rs1_q       <= dec_rs1;
                rs2_q       <= bus.instr[24:20];
                use_imm_q   <= dec_use_imm;
                imm_q       <= dec_imm;
                illegal_q   <= dec_illegal;
                if (dec_mul) begin
                    state   <= MULWAIT;
                    mul_cnt <= MUL_LOAD;
                end else begin
                    state   <= FULL;
                    mul_cnt <= '0;
                end
            end else begin
                unique case (state)
                    FULL: begin
                        if (bus.out_ready) state <= EMPTY;
                    end
                    MULWAIT: begin
                        if (mul_cnt == '0) state <= FULL;
                        else               mul_cnt <= mul_cnt - MC_W'(1);
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign busy          = (state == MULWAIT);
    assign bus.reg_write = reg_write_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.use_imm   = use_imm_q;
    assign bus.imm       = imm_q;
    assign bus.illegal   = illegal_q;

endmodule
